// File: rtl/rf_access_pkg.sv
// Shared types for the register-file access master: command opcodes and FSM states.
// The dump feature of rf_access_master is enabled by defining RF_ACCESS_DUMP_EN.
package rf_access_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DUMP  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/rf_access_master.sv
// Command/response front end that reads, writes or dumps a register file one access at a time.
// Define RF_ACCESS_DUMP_EN to enable the dump op; otherwise op 10 is answered as an error.
module rf_access_master
  import rf_access_pkg::*;
#(
  parameter int bit_width = 32,
  parameter int sel_width = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [sel_width-1:0] cmd_sel,
  input  logic [bit_width-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [sel_width-1:0] rsp_sel,
  output logic [bit_width-1:0] rsp_data,
  output logic                 rsp_last,
  output logic                 rsp_err,
  output logic [sel_width-1:0] rf_sel_a,
  input  logic [bit_width-1:0] rf_data_out_a,
  output logic [sel_width-1:0] rf_sel_c,
  output logic [bit_width-1:0] rf_data_in,
  output logic                 rf_sel_en,
  output logic                 busy
);

  localparam logic [sel_width-1:0] SEL_MAX = '1;

  state_e               state;
  logic [sel_width-1:0] sel_q;
  logic [bit_width-1:0] data_q;
`ifdef RF_ACCESS_DUMP_EN
  logic [sel_width-1:0] dump_idx;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Register-file ports are decoded from state so they are zero outside their access cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rf_sel_a   = '0;
    rf_sel_c   = '0;
    rf_data_in = '0;
    rf_sel_en  = 1'b0;
    case (state)
      ST_READ:  rf_sel_a = sel_q;
      ST_WRITE: begin
        rf_sel_c   = sel_q;
        rf_data_in = data_q;
        rf_sel_en  = 1'b1;
      end
`ifdef RF_ACCESS_DUMP_EN
      ST_DUMP:  rf_sel_a = dump_idx;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      state    <= ST_IDLE;
      sel_q    <= '0;
      data_q   <= '0;
      rsp_sel  <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_err  <= 1'b0;
`ifdef RF_ACCESS_DUMP_EN
      dump_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            sel_q    <= cmd_sel;
            data_q   <= cmd_data;
            rsp_sel  <= cmd_sel;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_last <= 1'b1;
            case (cmd_op_e'(cmd_op))
              OP_READ:  state <= ST_READ;
              OP_WRITE: state <= ST_WRITE;
`ifdef RF_ACCESS_DUMP_EN
              OP_DUMP: begin
                dump_idx <= '0;
                state    <= ST_DUMP;
              end
`endif
              default: begin
                rsp_err <= 1'b1;
                state   <= ST_RESP;
              end
            endcase
          end
        end
        ST_READ: begin
          rsp_data <= rf_data_out_a;
          state    <= ST_RESP;
        end
        ST_WRITE: begin
          rsp_data <= data_q;
          state    <= ST_RESP;
        end
`ifdef RF_ACCESS_DUMP_EN
        ST_DUMP: begin
          rsp_sel  <= dump_idx;
          rsp_data <= rf_data_out_a;
          rsp_last <= (dump_idx == SEL_MAX);
          state    <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
`ifdef RF_ACCESS_DUMP_EN
            // Only non-final dump responses carry rsp_last=0, so it selects continue vs. done.
            if (rsp_last) begin
              state <= ST_IDLE;
            end else begin
              dump_idx <= dump_idx + 1'b1;
              state    <= ST_DUMP;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_master.sv
// Randomized self-checking bench for rf_access_master with a register-file model and response scoreboard.
// Expectations follow RF_ACCESS_DUMP_EN the same way the design does.
module tb_rf_access_master;

  localparam int BW   = 32;
  localparam int SW   = 5;
  localparam int NREG = 1 << SW;

  typedef struct {
    logic [SW-1:0] sel;
    logic [BW-1:0] data;
    logic          last;
    logic          err;
  } rsp_t;

  typedef struct {
    logic [SW-1:0] sel;
    logic [BW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [SW-1:0] cmd_sel = '0;
  logic [BW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [SW-1:0] rsp_sel;
  logic [BW-1:0] rsp_data;
  logic          rsp_last;
  logic          rsp_err;
  logic [SW-1:0] rf_sel_a;
  logic [BW-1:0] rf_data_out_a;
  logic [SW-1:0] rf_sel_c;
  logic [BW-1:0] rf_data_in;
  logic          rf_sel_en;
  logic          busy;

  logic [BW-1:0] rf_mem [NREG];
  logic [BW-1:0] ref_rf [NREG];
  rsp_t          exp_q[$];
  wr_t           wr_q[$];
  int            ready_mode = 2;
  int            n_checks = 0;
  int            n_errors = 0;
  int            wr_pulses = 0;
  int            rsp_hs = 0;

  rf_access_master #(.bit_width(BW), .sel_width(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rf_sel_a(rf_sel_a), .rf_data_out_a(rf_data_out_a),
    .rf_sel_c(rf_sel_c), .rf_data_in(rf_data_in), .rf_sel_en(rf_sel_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign rf_data_out_a = rf_mem[rf_sel_a];

  always @(posedge clk) begin
    if (rst_n && rf_sel_en) rf_mem[rf_sel_c] <= rf_data_in;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'($urandom_range(0, 1));
      1:       rsp_ready = ~rsp_ready;
      2:       rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
  end

  // Scoreboard: every visible response must equal the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_sel", 64'(rsp_sel), 64'(exp_q[0].sel));
          check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
          check("rsp_last", 64'(rsp_last), 64'(exp_q[0].last));
          check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_hs++;
          end
        end
      end
      if (rf_sel_en) begin
        wr_pulses++;
        if (wr_q.size() == 0) begin
          check("spurious_write", 64'(rf_sel_en), 64'd0);
        end else begin
          check("wr_sel", 64'(rf_sel_c), 64'(wr_q[0].sel));
          check("wr_data", 64'(rf_data_in), 64'(wr_q[0].data));
          void'(wr_q.pop_front());
        end
      end
    end
  end

  function automatic rsp_t mk_rsp(input logic [SW-1:0] sel, input logic [BW-1:0] data,
                                  input logic last, input logic err);
    rsp_t r;
    r.sel = sel; r.data = data; r.last = last; r.err = err;
    return r;
  endfunction

  // Offers one command once the master is idle; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [SW-1:0] sel, input logic [BW-1:0] data);
    int  n = 0;
    wr_t w;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("cmd_ready_timeout", 64'd0, 64'd1);
    case (op)
      2'b00: exp_q.push_back(mk_rsp(sel, ref_rf[sel], 1'b1, 1'b0));
      2'b01: begin
        ref_rf[sel] = data;
        w.sel = sel; w.data = data;
        wr_q.push_back(w);
        exp_q.push_back(mk_rsp(sel, data, 1'b1, 1'b0));
      end
`ifdef RF_ACCESS_DUMP_EN
      2'b10: for (int i = 0; i < NREG; i++)
        exp_q.push_back(mk_rsp(SW'(i), ref_rf[i], i == NREG - 1, 1'b0));
`endif
      default: exp_q.push_back(mk_rsp(sel, '0, 1'b1, 1'b1));
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_sel   = SW'($urandom);
    cmd_data  = $urandom;
    cmd_op    = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset_pulse();
    int n;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_sel", 64'(rsp_sel), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rf_sel_en", 64'(rf_sel_en), 64'd0);
    check("rst_rf_sel_a", 64'(rf_sel_a), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = wr_pulses;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("post_rst_no_write", 64'(wr_pulses), 64'(n));
  endtask

  initial begin
    int n;
    int pulses0;
    int hs0;
    int dumps;
    logic [1:0] op;

    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = $urandom;
      ref_rf[i] = rf_mem[i];
    end

    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rf_sel_en", 64'(rf_sel_en), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write 0xDEADBEEF to index 3 and read it back with the exact one-cycle latency.
    ready_mode = 2;
    pulses0 = wr_pulses;
    issue(2'b01, 5'd3, 32'hDEADBEEF);
    drain();
    check("write_pulses", 64'(wr_pulses - pulses0), 64'd1);
    check("rf_mem3", 64'(rf_mem[3]), 64'hDEADBEEF);
    issue(2'b00, 5'd3, 32'h0);
    check("read_valid_at_accept", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("read_valid_next", 64'(rsp_valid), 64'd1);
    check("read_data_lit", 64'(rsp_data), 64'hDEADBEEF);
    drain();

    // Reserved op: immediate error response, no write.
    pulses0 = wr_pulses;
    ready_mode = 3;
    issue(2'b11, 5'd7, 32'h12345678);
    check("rsvd_err_lit", 64'(rsp_err), 64'd1);
    check("rsvd_data_lit", 64'(rsp_data), 64'd0);
    check("rsvd_sel_lit", 64'(rsp_sel), 64'd7);
    check("rsvd_last_lit", 64'(rsp_last), 64'd1);
    ready_mode = 2;
    drain();
    check("rsvd_no_write", 64'(wr_pulses), 64'(pulses0));

    // Index 31 behaves as an ordinary register.
    issue(2'b01, 5'd31, 32'hA5A5_0031);
    issue(2'b00, 5'd31, 32'h0);
    drain();

`ifdef RF_ACCESS_DUMP_EN
    for (int i = 0; i < NREG; i++) issue(2'b01, SW'(i), 32'h100 + 32'(i));
    drain();
    ready_mode = 1;
    hs0 = rsp_hs;
    issue(2'b10, 5'd0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dump_first_lit", 64'(rsp_data), 64'h100);
    drain();
    check("dump_count", 64'(rsp_hs - hs0), 64'(NREG));

    // Reset while the 10th dump response is on the bus.
    hs0 = rsp_hs;
    issue(2'b10, 5'd0, 32'h0);
    n = 0;
    while (!(rsp_valid && rsp_hs - hs0 == 9) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("dump10_reached", 64'(rsp_sel), 64'd9);
    #1;
    do_reset_pulse();
`else
    ready_mode = 3;
    issue(2'b10, 5'd4, 32'h0);
    check("nodump_err_lit", 64'(rsp_err), 64'd1);
    check("nodump_last_lit", 64'(rsp_last), 64'd1);
    ready_mode = 2;
    drain();

    // Reset while a read response is stalled.
    ready_mode = 3;
    issue(2'b00, 5'd9, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("stall_valid", 64'(rsp_valid), 64'd1);
    #1;
    do_reset_pulse();
`endif

    // Random traffic with random backpressure.
    dumps = 0;
    for (int k = 0; k < 80; k++) begin
      if (k % 10 == 0) ready_mode = $urandom_range(0, 2);
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10) begin
        if (dumps >= 2) op = 2'b00;
        else dumps++;
      end
      issue(op, SW'($urandom), $urandom);
    end
    ready_mode = 2;
    drain();
    check("final_wr_q_empty", 64'(wr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_access_master.md
RF_ACCESS_MASTER -- requirements
Module: rf_access_master

Interface
REQ-001 Parameter bit_width, default 32, register data width.
REQ-002 Parameter sel_width, default 5, register index width; register count is 2**sel_width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  00 read, 01 write, 10 dump, 11 reserved.
REQ-008 cmd_sel  input  sel_width  target register index.
REQ-009 cmd_data  input  bit_width  write data.
REQ-010 rsp_valid  output  1  response offered.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_sel  output  sel_width  register index of response.
REQ-013 rsp_data  output  bit_width  register value (read/dump), written value (write), 0 (error).
REQ-014 rsp_last  output  1  final response of a command.
REQ-015 rsp_err  output  1  command rejected as reserved/unsupported.
REQ-016 rf_sel_a  output  sel_width  register file read select.
REQ-017 rf_data_out_a  input  bit_width  register file read data, combinational from rf_sel_a.
REQ-018 rf_sel_c  output  sel_width  register file write select.
REQ-019 rf_data_in  output  bit_width  register file write data.
REQ-020 rf_sel_en  output  1  register file write enable.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, READ, WRITE, DUMP, RESP, shall be used; cmd_ready = (state == IDLE).
REQ-023 Accept in IDLE: op 00 -> READ, 01 -> WRITE, 10 -> DUMP, 11 -> RESP with rsp_err=1, rsp_data=0, rsp_sel=cmd_sel, rsp_last=1.
REQ-024 READ lasts one cycle, drives rf_sel_a=cmd_sel, captures rf_data_out_a at its end; -> RESP with rsp_last=1; rsp_valid rises one cycle after accept.
REQ-025 WRITE lasts one cycle, rf_sel_en=1, rf_sel_c=cmd_sel, rf_data_in=cmd_data; -> RESP with rsp_data=cmd_data, rsp_last=1.
REQ-026 rf_sel_en is high only in WRITE; exactly one pulse per write command.
REQ-027 DUMP walks index 0 to 2**sel_width-1: drive rf_sel_a=idx, capture into response, -> RESP; on its consumption, if idx is the maximum, -> IDLE, else idx+1 and -> DUMP.
REQ-028 Dump response for the maximum index carries rsp_last=1; all others 0; index counter does not wrap.
REQ-029 RESP holds rsp_valid=1 and rsp_* stable until rsp_ready; on handshake single-response commands -> IDLE.
REQ-030 rsp_valid=0 in every state except RESP.
REQ-031 cmd_sel/cmd_data are latched at accept; later input changes have no effect.
REQ-032 Index 2**sel_width-1 (PC) is read/written like any other; no special handling.

Reset
REQ-033 rst_n low: state IDLE, dump index 0, rsp_valid/rsp_last/rsp_err/rf_sel_en=0, rsp_sel/rsp_data/rf_sel_a/rf_sel_c/rf_data_in=0, busy=0.
REQ-034 Reset mid-dump or mid-response aborts the command; no further response or write follows.

Configuration
REQ-035 Macro RF_ACCESS_DUMP_EN defined: dump op 10 as in REQ-027.
REQ-036 Macro RF_ACCESS_DUMP_EN undefined: DUMP state and index counter absent; op 10 handled as reserved (rsp_err=1, single response).

Structure
REQ-037 Package rf_access_pkg holds the cmd_op enum (OP_READ, OP_WRITE, OP_DUMP, OP_RSVD) and the FSM state enum.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Write op 01, sel 3, data 0xDEADBEEF -> one rf_sel_en pulse with rf_sel_c=3; response sel 3, data 0xDEADBEEF, last 1, err 0.
REQ-040 Read sel 3 after REQ-039 against a register file model -> rsp_data 0xDEADBEEF one cycle after accept.
REQ-041 Dump with registers preloaded to 0x100+idx, rsp_ready toggled 1/0 -> 32 responses, data 0x100..0x11F in order, stable under stall, rsp_last only on idx 31.
REQ-042 Op 11 sel 7 -> response err 1, data 0, sel 7, last 1; no rf_sel_en.
REQ-043 rst_n pulsed low at the 10th dump response -> all outputs 0 immediately, IDLE, cmd_ready 1 after release.
REQ-044 Build without RF_ACCESS_DUMP_EN, op 10 -> single response err 1, last 1.
